// File: rtl/sram_mem_ctrl_pkg.sv
// Shared FSM encodings, default parameters and the latched request record
// for the MEM-stage SRAM controller.
package sram_mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned DEF_WAIT_STATES = 1;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic int unsigned cnt_width(input int unsigned ws);
        return (ws == 0) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// CPU-side MEM-stage bus: level load/store request in, completion pulse,
// load word and pipeline freeze out.
interface sram_mem_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;

    modport master (output mem_r_en, mem_w_en, addr, wdata, input rdata, ready, freeze);
    modport slave  (input mem_r_en, mem_w_en, addr, wdata, output rdata, ready, freeze);
endinterface

// File: rtl/sram_wait_counter.sv
// Phase-length counter: counts 0..WAIT_STATES while enabled and wraps,
// flagging the last cycle of each SRAM halfword phase.
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int unsigned   CW       = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_STATES);

    logic [CW-1:0] cnt;

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit load/store into two halfword cycles on an async 16-bit SRAM.
// Latency: ready pulses 1+2*(WAIT_STATES+1) cycles after the request is seen in IDLE.
// Backpressure: freeze holds the pipeline while a request is pending and not yet ready.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_mem_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    logic [1:0]     state;
    logic [1:0]     nxt_state;
    req_t           req_q;
    req_t           req_n;
    logic [SRAM_AW:0] off;
    logic [15:0]    lo_q;
    logic           cnt_last;
    logic           in_phase;
    logic           act_n;
    logic           hw_n;
    logic           ready;
    logic           unused_off;

    // Request fields are only taken from the bus in IDLE; afterwards the latched copy rules.
    always_comb begin
        req_n = req_q;
        if (state == ST_IDLE) begin
            req_n.wr    = bus.mem_w_en;
            req_n.addr  = bus.addr;
            req_n.wdata = bus.wdata;
        end
    end

    // Low bits of a difference depend only on low bits, so the narrow subtract is exact.
    assign off        = req_n.addr[SRAM_AW:0] - BASE[SRAM_AW:0];
    assign unused_off = ^off[1:0];

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: if (bus.mem_r_en | bus.mem_w_en) nxt_state = ST_LO;
            ST_LO:   if (cnt_last) nxt_state = ST_HI;
            ST_HI:   if (cnt_last) nxt_state = ST_DONE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    assign in_phase = (state == ST_LO) || (state == ST_HI);
    assign act_n    = (nxt_state == ST_LO) || (nxt_state == ST_HI);
    assign hw_n     = (nxt_state == ST_HI);

    sram_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~in_phase),
        .en    (in_phase),
        .last  (cnt_last)
    );

    // SRAM pins are registered from next-state so strobes change cleanly on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            lo_q        <= '0;
            bus.rdata   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state      <= nxt_state;
            req_q      <= req_n;
            sram_dq_oe <= act_n & req_n.wr;
            sram_we_n  <= ~(act_n & req_n.wr);
            sram_oe_n  <= ~(act_n & ~req_n.wr);
            if (act_n) begin
                sram_addr <= {off[SRAM_AW:2], hw_n};
            end
            if (act_n && req_n.wr) begin
                sram_dq_out <= hw_n ? req_n.wdata[31:16] : req_n.wdata[15:0];
            end
            if (state == ST_LO && cnt_last) begin
                lo_q <= sram_dq_in;
            end
            // Publish the whole word at once so rdata never shows a half-updated load.
            if (state == ST_HI && cnt_last && !req_q.wr) begin
                bus.rdata <= {sram_dq_in, lo_q};
            end
        end
    end

    assign ready      = (state == ST_DONE);
    assign bus.ready  = ready;
    assign bus.freeze = (bus.mem_r_en | bus.mem_w_en) & ~ready;
endmodule
